eth_frame_builder: RTL and testbench

- Upstream stage of the PHY transmit block; fills the shared 2048x8 transmit frame RAM (ipmem) with one complete Ethernet/IPv4/UDP frame, then hands it over via cpy_ready/phy_ready.
- Frame contents: preamble, SFD, MAC header, IPv4 header with computed checksum, UDP header, payload bytes from a payload RAM, and CRC-32 FCS.
- Runs on the same 250 MHz clock as the transmitter, so no CDC on the handshake.

---
 rtl/eth_pkg.sv | 36 +++
 rtl/eth_crc32_d8.sv | 25 ++
 rtl/eth_frame_builder.sv | 180 ++++++++++++++++++
 tb/tb_eth_frame_builder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, state type and CRC step function for the Ethernet/IPv4/UDP frame builder.
package eth_pkg;

    localparam int unsigned DEF_FRAME_LEN   = 1199;
    localparam int unsigned DEF_PAYLOAD_LEN = 1145;

    localparam int unsigned OFS_DST = 8;
    localparam int unsigned OFS_IP  = 22;
    localparam int unsigned OFS_UDP = 42;
    localparam int unsigned OFS_PAY = 50;
    localparam int unsigned OFS_FCS = DEF_FRAME_LEN - 4;

    localparam int unsigned IP_WORDS = 10;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB88320;

    typedef enum logic [2:0] {IDLE, CALC, WRITE, DONE, HANDOFF, WAIT_TX} state_t;

    // One byte of reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 register; init preloads all ones, enable folds in one byte.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_init) begin
            r_crc <= 32'hFFFFFFFF;
        end else if (i_en) begin
            r_crc <= crc32_step(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/eth_frame_builder.sv
// Builds one Ethernet/IPv4/UDP frame into the transmit RAM and hands it to the transmitter.
module eth_frame_builder
    import eth_pkg::*;
#(
    parameter int unsigned FRAME_LEN   = DEF_FRAME_LEN,
    parameter int unsigned PAYLOAD_LEN = DEF_PAYLOAD_LEN,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0012345678AB,
    parameter logic [31:0] SRC_IP      = 32'hC0A80102,
    parameter logic [31:0] DST_IP      = 32'hC0A801FF,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd5000
) (
    input  logic        clock250_0,
    input  logic        rst,
    input  logic        send_en,
    input  logic        phy_ready,
    output logic        cpy_ready,
    output logic [10:0] ipmem_wr_address,
    output logic [7:0]  ipmem_data,
    output logic        ipmem_wren,
    output logic [10:0] payload_address,
    input  logic [7:0]  payload_q,
    output logic [15:0] frame_count
);

    localparam logic [10:0] A_LAST         = 11'(FRAME_LEN - 1);
    localparam logic [10:0] A_FCS          = 11'(FRAME_LEN - 4);
    localparam logic [10:0] A_PAY          = 11'(OFS_PAY);
    localparam logic [10:0] A_CRC_LO       = 11'(OFS_DST);
    localparam logic [10:0] A_PREFETCH     = 11'(OFS_PAY - 2);
    localparam logic [10:0] A_PREFETCH_END = 11'(OFS_PAY - 2 + PAYLOAD_LEN);
    localparam logic [15:0] IP_TOTAL_LEN   = 16'(28 + PAYLOAD_LEN);
    localparam logic [15:0] UDP_LEN        = 16'(8 + PAYLOAD_LEN);
    localparam logic [3:0]  CALC_LAST      = 4'(IP_WORDS);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [19:0] r_acc;
    logic [15:0] r_cks;
    logic [15:0] r_ip_id;
    logic [10:0] r_idx;
    logic        r_wren;
    logic [10:0] r_addr;
    logic [7:0]  r_data;
    logic [10:0] r_pay_addr;
    logic        r_cpy;
    logic [15:0] r_frame_cnt;

    logic [159:0] w_ip_hdr;
    logic [399:0] w_hdr;
    logic [15:0]  w_word;
    logic [16:0]  w_fold1;
    logic [15:0]  w_fold2;
    logic [15:0]  w_cks;
    logic [7:0]   w_hdr_byte;
    logic [7:0]   w_fcs_byte;
    logic [7:0]   w_byte;
    logic [31:0]  w_crc;
    logic         w_crc_en;
    logic         w_crc_init;

    // IPv4 header as summed for the checksum (checksum field zero).
    assign w_ip_hdr = {IP_VER_IHL, 8'h00, IP_TOTAL_LEN, r_ip_id, IP_FLAGS_DF,
                       IP_TTL, IP_PROTO_UDP, 16'h0000, SRC_IP, DST_IP};

    // Bytes 0..49 as they go on the wire, first byte in the top bits.
    assign w_hdr = {{7{PREAMBLE_BYTE}}, SFD_BYTE, DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    IP_VER_IHL, 8'h00, IP_TOTAL_LEN, r_ip_id, IP_FLAGS_DF,
                    IP_TTL, IP_PROTO_UDP, r_cks, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

    assign w_word     = 16'(w_ip_hdr >> {4'(4'd9 - r_cnt), 4'b0000});
    assign w_fold1    = {1'b0, r_acc[15:0]} + {13'h0000, r_acc[19:16]};
    assign w_fold2    = w_fold1[15:0] + {15'h0000, w_fold1[16]};
    assign w_cks      = ~w_fold2;
    assign w_hdr_byte = 8'(w_hdr >> {6'(6'd49 - r_idx[5:0]), 3'b000});
    assign w_fcs_byte = 8'(~w_crc >> {2'(r_idx - A_FCS), 3'b000});

    always_comb begin
        w_byte = 8'h00;
        if (r_idx < A_PAY) begin
            w_byte = w_hdr_byte;
        end else if (r_idx < A_FCS) begin
            w_byte = payload_q;
        end else begin
            w_byte = w_fcs_byte;
        end
    end

    assign w_crc_init = (r_state == CALC);
    assign w_crc_en   = (r_state == WRITE) && (r_idx >= A_CRC_LO) && (r_idx < A_FCS);

    eth_crc32_d8 u_crc (
        .i_clk  (clock250_0),
        .i_rst  (rst),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (w_byte),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clock250_0) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_acc       <= 20'd0;
            r_cks       <= 16'h0000;
            r_ip_id     <= 16'h0000;
            r_idx       <= 11'd0;
            r_wren      <= 1'b0;
            r_addr      <= 11'd0;
            r_data      <= 8'h00;
            r_pay_addr  <= 11'd0;
            r_cpy       <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (send_en && phy_ready) begin
                        r_state <= CALC;
                        r_cnt   <= 4'd0;
                        r_acc   <= 20'd0;
                    end
                end
                CALC: begin
                    if (r_cnt == CALC_LAST) begin
                        r_cks   <= w_cks;
                        r_idx   <= 11'd0;
                        r_state <= WRITE;
                    end else begin
                        r_acc <= r_acc + {4'h0, w_word};
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                WRITE: begin
                    r_wren <= 1'b1;
                    r_addr <= r_idx;
                    r_data <= w_byte;
                    // Payload RAM address runs two bytes ahead to cover its read latency.
                    if ((r_idx >= A_PREFETCH) && (r_idx < A_PREFETCH_END)) begin
                        r_pay_addr <= r_idx - A_PREFETCH;
                    end
                    if (r_idx == A_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 11'd1;
                    end
                end
                DONE: begin
                    r_cpy       <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_ip_id     <= r_ip_id + 16'd1;
                    r_state     <= HANDOFF;
                end
                HANDOFF: begin
                    if (!phy_ready) begin
                        r_cpy   <= 1'b0;
                        r_state <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (phy_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpy_ready        = r_cpy;
    assign ipmem_wr_address = r_addr;
    assign ipmem_data       = r_data;
    assign ipmem_wren       = r_wren;
    assign payload_address  = r_pay_addr;
    assign frame_count      = r_frame_cnt;

endmodule

// File: tb/tb_eth_frame_builder.sv
// Self-checking bench for eth_frame_builder: RAM models, frame reference model, scenario tasks.
module tb_eth_frame_builder;

    localparam int FLEN = 1199;
    localparam int PLEN = 1145;

    logic        clk;
    logic        rst;
    logic        send_en;
    logic        phy_ready;
    logic        cpy_ready;
    logic [10:0] ipmem_wr_address;
    logic [7:0]  ipmem_data;
    logic        ipmem_wren;
    logic [10:0] payload_address;
    logic [7:0]  payload_q;
    logic [15:0] frame_count;

    logic        u_init;
    logic        u_en;
    logic [7:0]  u_data;
    logic [31:0] u_crc;

    logic [7:0] ram  [2048];
    logic [7:0] pram [2048];
    logic [7:0] expf [2048];
    logic [15:0] exp_cks;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int busy_wr = 0;

    eth_frame_builder dut (
        .clock250_0       (clk),
        .rst              (rst),
        .send_en          (send_en),
        .phy_ready        (phy_ready),
        .cpy_ready        (cpy_ready),
        .ipmem_wr_address (ipmem_wr_address),
        .ipmem_data       (ipmem_data),
        .ipmem_wren       (ipmem_wren),
        .payload_address  (payload_address),
        .payload_q        (payload_q),
        .frame_count      (frame_count)
    );

    eth_crc32_d8 u_crc_unit (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_init (u_init),
        .i_en   (u_en),
        .i_data (u_data),
        .o_crc  (u_crc)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    // Frame RAM and synchronous payload RAM.
    always @(posedge clk) begin
        if (ipmem_wren) ram[ipmem_wr_address] <= ipmem_data;
        payload_q <= pram[payload_address];
    end

    always @(negedge clk) begin
        if (ipmem_wren) begin
            wr_cnt++;
            if (!phy_ready) busy_wr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cpy(output int n);
        n = 0;
        while (cpy_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ d[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic randomize_payload();
        for (int i = 0; i < 2048; i++) pram[i] = 8'($urandom);
    endtask

    // Reference frame from the wire format: constant header, ones-complement sum, CRC.
    task automatic build_expected(input logic [15:0] id);
        logic [7:0] h [50];
        int unsigned sum;
        logic [31:0] c;
        h = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'h08, 8'h00,
              8'h45, 8'h00, 8'h04, 8'h95, id[15:8], id[7:0], 8'h40, 8'h00,
              8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h02,
              8'hC0, 8'hA8, 8'h01, 8'hFF,
              8'h13, 8'h88, 8'h13, 8'h88, 8'h04, 8'h81, 8'h00, 8'h00};
        sum = 0;
        for (int k = 0; k < 10; k++) sum += {h[22 + 2 * k], h[23 + 2 * k]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        exp_cks = ~16'(sum);
        h[32] = exp_cks[15:8];
        h[33] = exp_cks[7:0];
        for (int i = 0; i < 50; i++) expf[i] = h[i];
        for (int i = 0; i < PLEN; i++) expf[50 + i] = pram[i];
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 1195; i++) c = crc_upd(c, expf[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) expf[1195 + i] = 8'(c >> (8 * i));
    endtask

    task automatic check_full_frame(input string tag);
        int nbad;
        int first;
        nbad = 0;
        first = -1;
        for (int i = 0; i < FLEN; i++) begin
            if (ram[i] !== expf[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s frame: %0d bytes differ, first at %0d got %h want %h",
                     tag, nbad, first, ram[first], expf[first]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        send_en = 1'b0;
        phy_ready = 1'b0;
        u_init = 1'b0;
        u_en = 1'b0;
        u_data = 8'h00;
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        tick();
        send_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({cpy_ready, ipmem_wren, ipmem_wr_address, ipmem_data, payload_address, frame_count} !== 48'h0) begin
            bad++;
            $display("FAIL reset_values: got cpy=%b wren=%b addr=%h data=%h paddr=%h fc=%h want all 0",
                     cpy_ready, ipmem_wren, ipmem_wr_address, ipmem_data, payload_address, frame_count);
        end
        wr_cnt = 0;
        repeat (2000) begin
            tick();
            if (cpy_ready !== 1'b0) break;
        end
        total++;
        if (wr_cnt != 0 || cpy_ready !== 1'b0 || frame_count !== 16'h0) begin
            bad++;
            $display("FAIL idle_no_phy: got writes=%0d cpy=%b fc=%0d want 0 0 0", wr_cnt, cpy_ready, frame_count);
        end
    endtask

    task automatic test_crc_unit();
        u_init = 1'b1;
        tick();
        u_init = 1'b0;
        u_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            u_data = 8'(8'h31 + i);
            tick();
        end
        u_en = 1'b0;
        total++;
        if (~u_crc !== 32'hCBF43926) begin
            bad++;
            $display("FAIL crc_check_value: got %h want cbf43926", ~u_crc);
        end
    endtask

    task automatic test_first_frame();
        int n;
        int sidx [18];
        logic [7:0] sval [18];
        logic [31:0] c;
        sidx = '{0, 1, 2, 3, 4, 5, 6, 7, 20, 21, 24, 25, 26, 27, 46, 47, 50, 1194};
        sval = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h08, 8'h00,
                 8'h04, 8'h95, 8'h00, 8'h00, 8'h04, 8'h81, 8'h00, 8'h78};
        for (int i = 0; i < 2048; i++) pram[i] = 8'(i);
        build_expected(16'h0000);
        phy_ready = 1'b1;
        tick();
        wait_cpy(n);
        total++;
        if (n != 1211) begin
            bad++;
            $display("FAIL first_latency: got %0d cycles want 1211", n);
        end
        total++;
        if (frame_count !== 16'd1 || ipmem_wren !== 1'b0) begin
            bad++;
            $display("FAIL first_done: got fc=%0d wren=%b want 1 0", frame_count, ipmem_wren);
        end
        for (int i = 0; i < 18; i++) begin
            total++;
            if (ram[sidx[i]] !== sval[i]) begin
                bad++;
                $display("FAIL byte_%0d: got %h want %h", sidx[i], ram[sidx[i]], sval[i]);
            end
        end
        total++;
        if ({ram[32], ram[33]} !== exp_cks) begin
            bad++;
            $display("FAIL ip_checksum: got %h want %h", {ram[32], ram[33]}, exp_cks);
        end
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 1195; i++) c = crc_upd(c, ram[i]);
        total++;
        if ({ram[1198], ram[1197], ram[1196], ram[1195]} !== ~c) begin
            bad++;
            $display("FAIL fcs: got %h want %h", {ram[1198], ram[1197], ram[1196], ram[1195]}, ~c);
        end
        check_full_frame("first");
    endtask

    task automatic test_handoff();
        int n;
        int busy0;
        busy0 = busy_wr;
        phy_ready = 1'b0;
        tick();
        total++;
        if (cpy_ready !== 1'b0) begin
            bad++;
            $display("FAIL handoff_fall: got cpy=%b want 0", cpy_ready);
        end
        randomize_payload();
        build_expected(16'h0001);
        repeat (2399) tick();
        total++;
        if (busy_wr != busy0 || cpy_ready !== 1'b0) begin
            bad++;
            $display("FAIL tx_owned: got writes=%0d cpy=%b want 0 0", busy_wr - busy0, cpy_ready);
        end
        phy_ready = 1'b1;
        tick();
        wait_cpy(n);
        total++;
        if (cpy_ready !== 1'b1 || frame_count !== 16'd2) begin
            bad++;
            $display("FAIL second_done: got cpy=%b fc=%0d want 1 2", cpy_ready, frame_count);
        end
        total++;
        if ({ram[26], ram[27], ram[32], ram[33]} !== {16'h0001, exp_cks}) begin
            bad++;
            $display("FAIL second_id_cks: got %h want %h", {ram[26], ram[27], ram[32], ram[33]}, {16'h0001, exp_cks});
        end
        check_full_frame("second");
    endtask

    task automatic test_send_en_drop();
        int n;
        int w0;
        phy_ready = 1'b0;
        repeat ($urandom_range(2, 6)) tick();
        randomize_payload();
        build_expected(16'h0002);
        phy_ready = 1'b1;
        n = 0;
        while (!(ipmem_wren === 1'b1 && ipmem_wr_address === 11'd600) && n < 3000) begin
            tick();
            n++;
        end
        send_en = 1'b0;
        wait_cpy(n);
        total++;
        if (cpy_ready !== 1'b1 || frame_count !== 16'd3) begin
            bad++;
            $display("FAIL drop_complete: got cpy=%b fc=%0d want 1 3", cpy_ready, frame_count);
        end
        check_full_frame("third");
        phy_ready = 1'b0;
        repeat (3) tick();
        phy_ready = 1'b1;
        w0 = wr_cnt;
        repeat (2000) tick();
        total++;
        if (wr_cnt != w0 || cpy_ready !== 1'b0 || frame_count !== 16'd3) begin
            bad++;
            $display("FAIL no_third_build: got writes=%0d cpy=%b fc=%0d want 0 0 3", wr_cnt - w0, cpy_ready, frame_count);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        int w0;
        send_en = 1'b1;
        n = 0;
        while (!(ipmem_wren === 1'b1 && ipmem_wr_address === 11'd300) && n < 3000) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_en = 1'b0;
        total++;
        if ({cpy_ready, ipmem_wren, ipmem_wr_address, frame_count} !== 29'h0) begin
            bad++;
            $display("FAIL rst_mid: got cpy=%b wren=%b addr=%0d fc=%0d want 0 0 0 0",
                     cpy_ready, ipmem_wren, ipmem_wr_address, frame_count);
        end
        w0 = wr_cnt;
        repeat ($urandom_range(3, 9)) tick();
        total++;
        if (wr_cnt != w0 || cpy_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle: got writes=%0d cpy=%b want 0 0", wr_cnt - w0, cpy_ready);
        end
        randomize_payload();
        build_expected(16'h0000);
        send_en = 1'b1;
        tick();
        wait_cpy(n);
        total++;
        if (n != 1211 || frame_count !== 16'd1) begin
            bad++;
            $display("FAIL rebuild: got latency=%0d fc=%0d want 1211 1", n, frame_count);
        end
        check_full_frame("rebuild");
    endtask

    initial begin
        test_reset();
        test_crc_unit();
        test_first_frame();
        test_handoff();
        test_send_en_drop();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
